// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: funct3 size/sign codes, LSU state encoding and
// the load/store helper functions used by the MEM stage.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_WAIT = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  // Unsigned sizes exist only for loads; halves need even, words need aligned addresses.
  function automatic logic lsu_legal(input logic we, input logic [2:0] f3,
                                     input logic [1:0] off);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << off;
      F3_H:    be = 4'b0011 << {off[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3)
      F3_B:    d = {4{wd[7:0]}};
      F3_H:    d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] dmem_rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = dmem_rdata[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3)
      F3_B:    ext_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    ext_data = {{16{half_sel[15]}}, half_sel};
      F3_W:    ext_data = dmem_rdata;
      F3_BU:   ext_data = {24'd0, byte_sel};
      F3_HU:   ext_data = {16'd0, half_sel};
      default: ext_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns a pipeline load/store into a ready-handshaked
// data-memory transaction, stalls until it completes or times out.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic             legal;
  logic             timeout_hit;
  logic [31:0]      ext_data;

  assign legal       = lsu_legal(mem_we, funct3, addr[1:0]);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  // Gated by rst so every output reads 0 while reset is held.
  assign stall = ~rst & (((state_q == LSU_IDLE) & mem_req & legal) | (state_q == LSU_WAIT));

  // Size/offset are captured at issue because the pipeline inputs may change in WAIT.
  load_extend u_load_extend (
    .dmem_rdata (dmem_rdata),
    .addr       (off_q),
    .funct3     (f3_q),
    .ext_data   (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LSU_IDLE;
      cnt_q      <= '0;
      f3_q       <= 3'd0;
      off_q      <= 2'd0;
      rdata      <= 32'd0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= 4'd0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
    end else begin
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      case (state_q)
        LSU_IDLE: begin
          if (mem_req) begin
            if (legal) begin
              state_q   <= LSU_WAIT;
              cnt_q     <= '0;
              f3_q      <= funct3;
              off_q     <= addr[1:0];
              dmem_req  <= 1'b1;
              dmem_we   <= mem_we;
              dmem_be   <= mem_we ? store_be(funct3, addr[1:0]) : 4'b1111;
              dmem_addr <= {addr[31:2], 2'b00};
              if (mem_we) dmem_wdata <= store_data(funct3, wdata);
            end else begin
              misaligned <= 1'b1;
            end
          end
        end
        LSU_WAIT: begin
          if (dmem_ready) begin
            state_q  <= LSU_DONE;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            dmem_be  <= 4'd0;
            if (!dmem_we) rdata <= ext_data;
          end else if (timeout_hit) begin
            state_q  <= LSU_DONE;
            bus_err  <= 1'b1;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            dmem_be  <= 4'd0;
            if (!dmem_we) rdata <= 32'd0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LSU_DONE: state_q <= LSU_IDLE;
        default:  state_q <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a short timeout so the abort path is reachable.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        misaligned;
  logic        bus_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  int checks = 0;
  int errors = 0;

  int          stall_n, wait_n, pulses, req_n;
  logic        stall_s;
  logic [3:0]  be_s;
  logic [31:0] addr_s, wdata_s;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .rdata      (rdata),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_be    (dmem_be),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one access; memory answers on WAIT cycle rdy_at (0 = never). Returns in DONE.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int rdy_at,
                           output int st_n, output int w_n, output logic [3:0] be_o,
                           output logic [31:0] addr_o, output logic [31:0] wdata_o);
    mem_req = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd; dmem_rdata = rd;
    st_n = 0; w_n = 0; be_o = 4'd0; addr_o = 32'd0; wdata_o = 32'd0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!stall) break;
      st_n++;
      if (dmem_req) begin
        w_n++;
        be_o = dmem_be; addr_o = dmem_addr; wdata_o = dmem_wdata;
      end
      dmem_ready = dmem_req && (w_n == rdy_at);
      tick();
    end
    mem_req = 1'b0;
    dmem_ready = 1'b0;
    check_eq("access_bound", {31'd0, stall}, 32'd0);
  endtask

  task automatic do_illegal(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            output logic st, output int p, output int r);
    mem_req = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = 32'hDEAD_BEEF;
    #1;
    st = stall;
    tick();
    mem_req = 1'b0;
    p = 0; r = 0;
    for (int c = 0; c < 3; c++) begin
      p += int'(misaligned);
      r += int'(dmem_req);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; funct3 = 3'd0; addr = 32'd0;
    wdata = 32'd0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
    tick(); tick();
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_req", {31'd0, dmem_req}, 32'd0);
    check_eq("rst_be", {28'd0, dmem_be}, 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    tick();

    // LB 0x103, ready on second WAIT cycle
    do_access(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_1234, 2,
              stall_n, wait_n, be_s, addr_s, wdata_s);
    check_eq("lb_rdata", rdata, 32'hFFFF_FF80);
    check_eq("lb_stall_n", stall_n, 32'd3);
    check_eq("lb_be", {28'd0, be_s}, 32'h0000_000F);
    check_eq("lb_addr", addr_s, 32'h0000_0100);
    check_eq("lb_done_req", {31'd0, dmem_req}, 32'd0);
    tick();

    // SH 0x202
    do_access(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h1111_1111, 1,
              stall_n, wait_n, be_s, addr_s, wdata_s);
    check_eq("sh_be", {28'd0, be_s}, 32'h0000_000C);
    check_eq("sh_wdata", wdata_s, 32'hABCD_ABCD);
    check_eq("sh_addr", addr_s, 32'h0000_0200);
    check_eq("sh_rdata_kept", rdata, 32'hFFFF_FF80);
    tick();

    // SB 0x301 and SW 0x404
    do_access(1'b1, 3'b000, 32'h0000_0301, 32'h0000_005A, 32'd0, 1,
              stall_n, wait_n, be_s, addr_s, wdata_s);
    check_eq("sb_be", {28'd0, be_s}, 32'h0000_0002);
    check_eq("sb_wdata", wdata_s, 32'h5A5A_5A5A);
    tick();
    do_access(1'b1, 3'b010, 32'h0000_0404, 32'h1234_5678, 32'd0, 1,
              stall_n, wait_n, be_s, addr_s, wdata_s);
    check_eq("sw_be", {28'd0, be_s}, 32'h0000_000F);
    check_eq("sw_wdata", wdata_s, 32'h1234_5678);
    check_eq("sw_addr", addr_s, 32'h0000_0404);
    tick();

    // Illegal accesses: LW misaligned, SB with unsigned size, funct3 011, LH odd
    do_illegal(1'b0, 3'b010, 32'h0000_0006, stall_s, pulses, req_n);
    check_eq("lw_mis_stall", {31'd0, stall_s}, 32'd0);
    check_eq("lw_mis_pulses", pulses, 32'd1);
    check_eq("lw_mis_req", req_n, 32'd0);
    do_illegal(1'b1, 3'b100, 32'h0000_0000, stall_s, pulses, req_n);
    check_eq("sbu_ill_pulses", pulses, 32'd1);
    check_eq("sbu_ill_req", req_n, 32'd0);
    do_illegal(1'b0, 3'b011, 32'h0000_0000, stall_s, pulses, req_n);
    check_eq("f3_011_pulses", pulses, 32'd1);
    do_illegal(1'b0, 3'b001, 32'h0000_0001, stall_s, pulses, req_n);
    check_eq("lh_odd_pulses", pulses, 32'd1);

    // LHU 0x002, ready on first WAIT cycle
    do_access(1'b0, 3'b101, 32'h0000_0002, 32'd0, 32'hF00D_1234, 1,
              stall_n, wait_n, be_s, addr_s, wdata_s);
    check_eq("lhu_rdata", rdata, 32'h0000_F00D);
    check_eq("lhu_stall_n", stall_n, 32'd2);
    tick();

    // LH sign-extend low half, LBU zero-extend byte 1
    do_access(1'b0, 3'b001, 32'h0000_0010, 32'd0, 32'h1234_8001, 1,
              stall_n, wait_n, be_s, addr_s, wdata_s);
    check_eq("lh_rdata", rdata, 32'hFFFF_8001);
    tick();
    do_access(1'b0, 3'b100, 32'h0000_0011, 32'd0, 32'h0000_F700, 1,
              stall_n, wait_n, be_s, addr_s, wdata_s);
    check_eq("lbu_rdata", rdata, 32'h0000_00F7);
    tick();

    // LW with no ready: abort after 4 WAIT cycles
    do_access(1'b0, 3'b010, 32'h0000_0010, 32'd0, 32'hCAFE_CAFE, 0,
              stall_n, wait_n, be_s, addr_s, wdata_s);
    check_eq("to_wait_n", wait_n, 32'd4);
    check_eq("to_bus_err", {31'd0, bus_err}, 32'd1);
    check_eq("to_rdata", rdata, 32'd0);
    check_eq("to_done_stall", {31'd0, stall}, 32'd0);
    tick();
    check_eq("to_bus_err_pulse", {31'd0, bus_err}, 32'd0);

    // Reset while in WAIT
    mem_req = 1'b1; mem_we = 1'b1; funct3 = 3'b010; addr = 32'h0000_0020;
    wdata = 32'h7777_7777;
    tick();
    mem_req = 1'b0;
    check_eq("rw_in_wait", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1;
    tick();
    check_eq("rw_req", {31'd0, dmem_req}, 32'd0);
    check_eq("rw_stall", {31'd0, stall}, 32'd0);
    check_eq("rw_addr", dmem_addr, 32'd0);
    check_eq("rw_wdata", dmem_wdata, 32'd0);
    check_eq("rw_be", {28'd0, dmem_be}, 32'd0);
    rst = 1'b0;
    tick();
    check_eq("rw_idle_req", {31'd0, dmem_req}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
